// File: rtl/cross_bar_pkg.sv
// Shared types and width helpers for the cross-bar family (demux router, mux, arbiter).
package cross_bar_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUTE = 2'd1,
    DROP  = 2'd2
  } xbar_state_e;

  // Bits needed to index n items; never returns 0 so single-entry selects stay legal.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Bits needed to hold the value n itself (e.g. an occupancy count 0..n).
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/cross_bar_fifo.sv
// First-word-fall-through FIFO; a write becomes visible on the output the following cycle.
module cross_bar_fifo
  import cross_bar_pkg::*;
#(
  parameter int unsigned WIDTH      = 33,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
  logic full, empty, push, pop;

  // Extra pointer MSB tells a full ring from an empty one.
  assign full  = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                 (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  assign push = in_valid_i && !full;
  assign pop  = out_ready_i && !empty;

  assign in_ready_o  = !full;
  assign out_valid_o = !empty;
  assign out_data_o  = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];

  assign wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= in_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/cross_bar_demux_router.sv
// 1:N AXI-Stream packet demux: the header beat selects an output channel, each channel buffered by its own FIFO.
module cross_bar_demux_router
  import cross_bar_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned CHANNEL_NO      = 4,
  parameter int unsigned DEST_WIDTH      = 2,
  parameter int unsigned DEST_LSB        = 0,
  parameter int unsigned HDR_STRIP       = 0,
  parameter int unsigned FIFO_ADDR_WIDTH = 5,
  parameter int unsigned CNT_WIDTH       = 16
) (
  input  logic                                 aclk,
  input  logic                                 aresetn,
  input  logic [DATA_WIDTH-1:0]                s_axis_tdata,
  input  logic                                 s_axis_tvalid,
  input  logic                                 s_axis_tlast,
  output logic                                 s_axis_tready,
  output logic [CHANNEL_NO-1:0][DATA_WIDTH-1:0] m_axis_tdata,
  output logic [CHANNEL_NO-1:0]                m_axis_tvalid,
  output logic [CHANNEL_NO-1:0]                m_axis_tlast,
  input  logic [CHANNEL_NO-1:0]                m_axis_tready,
  output logic [CNT_WIDTH-1:0]                 drop_count,
  output logic                                 busy
);

  localparam logic [DEST_WIDTH:0] CH_LIMIT = (DEST_WIDTH + 1)'(CHANNEL_NO);
  localparam bit                  STRIP    = (HDR_STRIP != 0);

  xbar_state_e             state_q, state_d;
  logic [DEST_WIDTH-1:0]   sel_q, sel_d;
  logic [CNT_WIDTH-1:0]    drop_q, drop_d;
  logic                    ready_en_q;
  logic                    drop_inc;

  logic [DEST_WIDTH-1:0]   hdr_dest;
  logic                    dest_ok;
  logic                    in_valid;
  logic                    sel_ready;
  logic                    route_en;
  logic                    s_ready;

  logic [CHANNEL_NO-1:0]   sel_onehot;
  logic [CHANNEL_NO-1:0]   fifo_wvalid;
  logic [CHANNEL_NO-1:0]   fifo_wready;
  logic [DATA_WIDTH:0]     fifo_rdata [CHANNEL_NO];

  assign hdr_dest = s_axis_tdata[DEST_LSB +: DEST_WIDTH];
  assign dest_ok  = ({1'b0, hdr_dest} < CH_LIMIT);
  // Ingress is ignored for the first cycle after reset release.
  assign in_valid = s_axis_tvalid && ready_en_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      drop_q     <= '0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      drop_q     <= drop_d;
      ready_en_q <= 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    drop_inc = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sel_d = hdr_dest;
          if (STRIP && s_axis_tlast) begin
            drop_inc = 1'b1;
          end else begin
            state_d = dest_ok ? ROUTE : DROP;
          end
        end
      end
      ROUTE: begin
        if (in_valid && sel_ready && s_axis_tlast) begin
          state_d = IDLE;
        end
      end
      DROP: begin
        if (in_valid && s_axis_tlast) begin
          state_d  = IDLE;
          drop_inc = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_ready  = 1'b0;
    route_en = 1'b0;
    case (state_q)
      IDLE:  s_ready = ready_en_q && STRIP;
      ROUTE: begin
        s_ready  = ready_en_q && sel_ready;
        route_en = ready_en_q;
      end
      DROP:  s_ready = ready_en_q;
      default: s_ready = 1'b0;
    endcase
  end

  assign drop_d = (drop_inc && (drop_q != {CNT_WIDTH{1'b1}})) ? drop_q + 1'b1 : drop_q;

  assign s_axis_tready = s_ready;
  assign drop_count    = drop_q;
  assign busy          = (state_q != IDLE);

  // Only the selected FIFO sees valid/last; data is broadcast to all of them.
  for (genvar gi = 0; gi < CHANNEL_NO; gi++) begin : g_ch
    assign sel_onehot[gi]  = (sel_q == DEST_WIDTH'(gi));
    assign fifo_wvalid[gi] = route_en && s_axis_tvalid && sel_onehot[gi];

    cross_bar_fifo #(
      .WIDTH     (DATA_WIDTH + 1),
      .ADDR_WIDTH(FIFO_ADDR_WIDTH)
    ) u_fifo (
      .clk        (aclk),
      .rst_n      (aresetn),
      .in_data_i  ({s_axis_tlast && fifo_wvalid[gi], s_axis_tdata}),
      .in_valid_i (fifo_wvalid[gi]),
      .in_ready_o (fifo_wready[gi]),
      .out_data_o (fifo_rdata[gi]),
      .out_valid_o(m_axis_tvalid[gi]),
      .out_ready_i(m_axis_tready[gi])
    );

    assign m_axis_tdata[gi] = fifo_rdata[gi][DATA_WIDTH-1:0];
    assign m_axis_tlast[gi] = fifo_rdata[gi][DATA_WIDTH];
  end

  assign sel_ready = |(fifo_wready & sel_onehot);

endmodule

// File: tb/tb_cross_bar_demux_router.sv
// Two router instances (forward mode / strip mode) checked against a packet-level reference model.
module tb_cross_bar_demux_router;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;
  logic aresetn;

  // dut0: 3 channels, 2-bit dest at bit 0, header forwarded, depth 4
  logic [31:0]      s0_tdata;
  logic             s0_tvalid, s0_tlast, s0_tready;
  logic [2:0][31:0] m0_tdata;
  logic [2:0]       m0_tvalid, m0_tlast, m0_tready;
  logic [15:0]      drop0;
  logic             busy0;

  // dut1: 4 channels, 3-bit dest at bit 4, header stripped, depth 4, 2-bit drop counter
  logic [31:0]      s1_tdata;
  logic             s1_tvalid, s1_tlast, s1_tready;
  logic [3:0][31:0] m1_tdata;
  logic [3:0]       m1_tvalid, m1_tlast, m1_tready;
  logic [1:0]       drop1;
  logic             busy1;

  cross_bar_demux_router #(
    .DATA_WIDTH(32), .CHANNEL_NO(3), .DEST_WIDTH(2), .DEST_LSB(0),
    .HDR_STRIP(0), .FIFO_ADDR_WIDTH(2), .CNT_WIDTH(16)
  ) u_dut0 (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s0_tdata), .s_axis_tvalid(s0_tvalid), .s_axis_tlast(s0_tlast), .s_axis_tready(s0_tready),
    .m_axis_tdata(m0_tdata), .m_axis_tvalid(m0_tvalid), .m_axis_tlast(m0_tlast), .m_axis_tready(m0_tready),
    .drop_count(drop0), .busy(busy0)
  );

  cross_bar_demux_router #(
    .DATA_WIDTH(32), .CHANNEL_NO(4), .DEST_WIDTH(3), .DEST_LSB(4),
    .HDR_STRIP(1), .FIFO_ADDR_WIDTH(2), .CNT_WIDTH(2)
  ) u_dut1 (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s1_tdata), .s_axis_tvalid(s1_tvalid), .s_axis_tlast(s1_tlast), .s_axis_tready(s1_tready),
    .m_axis_tdata(m1_tdata), .m_axis_tvalid(m1_tvalid), .m_axis_tlast(m1_tlast), .m_axis_tready(m1_tready),
    .drop_count(drop1), .busy(busy1)
  );

  int checks = 0;
  int fails  = 0;

  logic [32:0] ing_q [2][$];   // beats still to be offered, {last,data}
  logic [32:0] exp_q [8][$];   // expected egress beats, index dut*4+channel
  logic [32:0] pkt_q [$];      // packet under construction
  int unsigned exp_drop [2];
  logic [2:0]  stall0;
  logic [3:0]  stall1;
  bit          rand_rdy, rand_gap;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_beat(input int q, input logic [32:0] got);
    logic [32:0] exp;
    if (exp_q[q].size() != 0) exp = exp_q[q].pop_front();
    else exp = 'x;
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL beat dut%0d ch%0d: got %h expected %h", q / 4, q % 4, got, exp);
    end
  endtask

  // Reference model: route or drop a whole packet from its header field.
  task automatic commit(input int d);
    int unsigned dest, nch, first, maxc;
    bit drop;
    dest  = (d == 0) ? (int'(pkt_q[0][31:0]) & 3) : ((int'(pkt_q[0][31:0]) >> 4) & 7);
    nch   = (d == 0) ? 3 : 4;
    maxc  = (d == 0) ? 65535 : 3;
    first = (d == 0) ? 0 : 1;
    drop  = ((d == 1) && (pkt_q.size() == 1)) || (dest >= nch);
    if (drop) exp_drop[d] = (exp_drop[d] == maxc) ? maxc : exp_drop[d] + 1;
    else for (int i = first; i < pkt_q.size(); i++) exp_q[d * 4 + dest].push_back(pkt_q[i]);
    foreach (pkt_q[i]) ing_q[d].push_back(pkt_q[i]);
    pkt_q.delete();
  endtask

  task automatic send_pkt(input int d, input int unsigned dest, input int len);
    logic [31:0] w;
    for (int b = 0; b < len; b++) begin
      w = $urandom;
      if (b == 0) begin
        if (d == 0) w[1:0] = dest[1:0];
        else        w[6:4] = dest[2:0];
      end
      pkt_q.push_back({(b == len - 1), w});
    end
    commit(d);
  endtask

  function automatic int outstanding();
    int n = ing_q[0].size() + ing_q[1].size();
    for (int i = 0; i < 8; i++) n += exp_q[i].size();
    return n;
  endfunction

  // One clock: observe handshakes at the falling edge, drive new inputs just after the rising edge.
  task automatic tick();
    bit held0, held1;
    @(negedge aclk);
    for (int c = 0; c < 3; c++) if (m0_tvalid[c] && m0_tready[c]) check_beat(c, {m0_tlast[c], m0_tdata[c]});
    for (int c = 0; c < 4; c++) if (m1_tvalid[c] && m1_tready[c]) check_beat(4 + c, {m1_tlast[c], m1_tdata[c]});
    held0 = s0_tvalid && !s0_tready;
    held1 = s1_tvalid && !s1_tready;
    if (s0_tvalid && s0_tready && ing_q[0].size() != 0) void'(ing_q[0].pop_front());
    if (s1_tvalid && s1_tready && ing_q[1].size() != 0) void'(ing_q[1].pop_front());
    @(posedge aclk);
    #1;
    m0_tready = rand_rdy ? (3'($urandom) & ~stall0) : ~stall0;
    m1_tready = rand_rdy ? (4'($urandom) & ~stall1) : ~stall1;
    if (ing_q[0].size() != 0 && (held0 || !rand_gap || $urandom_range(0, 3) != 0)) begin
      s0_tvalid = 1'b1;
      {s0_tlast, s0_tdata} = ing_q[0][0];
    end else begin
      s0_tvalid = 1'b0; s0_tlast = 1'b0; s0_tdata = '0;
    end
    if (ing_q[1].size() != 0 && (held1 || !rand_gap || $urandom_range(0, 3) != 0)) begin
      s1_tvalid = 1'b1;
      {s1_tlast, s1_tdata} = ing_q[1][0];
    end else begin
      s1_tvalid = 1'b0; s1_tlast = 1'b0; s1_tdata = '0;
    end
  endtask

  task automatic drain(input string tag, input int limit);
    int n = 0;
    while (outstanding() != 0 && n < limit) begin
      tick();
      n++;
    end
    chk({tag, " drain outstanding"}, 64'(outstanding()), 64'd0);
  endtask

  initial begin
    aresetn = 1'b0;
    s0_tdata = '0; s0_tvalid = 1'b0; s0_tlast = 1'b0; m0_tready = '1;
    s1_tdata = '0; s1_tvalid = 1'b0; s1_tlast = 1'b0; m1_tready = '1;
    stall0 = '0; stall1 = '0; rand_rdy = 1'b0; rand_gap = 1'b0;
    exp_drop[0] = 0; exp_drop[1] = 0;
    repeat (3) tick();

    chk("rst s0_tready", 64'(s0_tready), 64'd0);
    chk("rst s1_tready", 64'(s1_tready), 64'd0);
    chk("rst m0_tvalid", 64'(m0_tvalid), 64'd0);
    chk("rst m1_tvalid", 64'(m1_tvalid), 64'd0);
    chk("rst drop0", 64'(drop0), 64'd0);
    chk("rst drop1", 64'(drop1), 64'd0);
    chk("rst busy0", 64'(busy0), 64'd0);
    chk("rst busy1", 64'(busy1), 64'd0);

    aresetn = 1'b1;
    #1;
    chk("tready held after release", 64'(s1_tready), 64'd0);
    tick();
    chk("strip idle tready", 64'(s1_tready), 64'd1);
    chk("fwd idle tready", 64'(s0_tready), 64'd0);

    // header forwarded: 4 beats on channel 2
    send_pkt(0, 2, 4);
    drain("fwd route", 200);
    chk("fwd busy after", 64'(busy0), 64'd0);

    // out-of-range destination dropped whole
    send_pkt(0, 3, 5);
    drain("fwd drop", 200);
    chk("fwd drop count", 64'(drop0), 64'd1);
    chk("fwd busy after drop", 64'(busy0), 64'd0);

    // stalled channel 0: ingress stops once the 4-deep FIFO fills
    stall0 = 3'b001;
    send_pkt(0, 0, 10);
    repeat (15) tick();
    chk("full fifo accepted", 64'(10 - ing_q[0].size()), 64'd4);
    chk("full fifo tready", 64'(s0_tready), 64'd0);
    chk("full fifo m0 valid", 64'(m0_tvalid), 64'b001);
    stall0 = '0;
    drain("full fifo release", 200);

    // packet to ch2 waits behind stalled ch1 packet
    stall0 = 3'b010;
    send_pkt(0, 1, 6);
    send_pkt(0, 2, 3);
    repeat (15) tick();
    chk("blocked ch2 waits", 64'(m0_tvalid), 64'b010);
    stall0 = '0;
    drain("blocked release", 200);

    // strip mode: only payload reaches channel 1
    pkt_q.push_back({1'b0, 32'h0000_0010});
    pkt_q.push_back({1'b0, 32'h0000_000A});
    pkt_q.push_back({1'b1, 32'h0000_000B});
    commit(1);
    drain("strip route", 200);
    pkt_q.push_back({1'b1, 32'h0000_0010});
    commit(1);
    drain("strip hdr only", 200);
    chk("strip empty pkt drop", 64'(drop1), 64'd1);
    for (int i = 0; i < 3; i++) begin
      pkt_q.push_back({1'b1, 32'h0000_0020});
      commit(1);
    end
    drain("strip saturate", 200);
    chk("drop saturates", 64'(drop1), 64'd3);

    // reset in the middle of a routed packet
    stall0 = 3'b010;
    send_pkt(0, 1, 8);
    repeat (6) tick();
    chk("mid-pkt busy", 64'(busy0), 64'd1);
    aresetn = 1'b0;
    ing_q[0].delete(); ing_q[1].delete();
    for (int i = 0; i < 8; i++) exp_q[i].delete();
    exp_drop[0] = 0; exp_drop[1] = 0;
    #1;
    chk("mid rst m0_tvalid", 64'(m0_tvalid), 64'd0);
    chk("mid rst m1_tvalid", 64'(m1_tvalid), 64'd0);
    chk("mid rst drop0", 64'(drop0), 64'd0);
    chk("mid rst drop1", 64'(drop1), 64'd0);
    chk("mid rst busy0", 64'(busy0), 64'd0);
    repeat (2) tick();
    aresetn = 1'b1;
    stall0 = '0;
    send_pkt(0, 0, 3);
    send_pkt(1, 6, 3);
    drain("post rst", 200);
    chk("post rst drop0", 64'(drop0), 64'd0);
    chk("post rst drop1", 64'(drop1), 64'd1);

    // random traffic with gaps and random backpressure
    rand_rdy = 1'b1;
    rand_gap = 1'b1;
    for (int i = 0; i < 40; i++) begin
      send_pkt(0, $urandom_range(0, 3), $urandom_range(1, 6));
      send_pkt(1, $urandom_range(0, 7), $urandom_range(1, 6));
    end
    drain("random", 8000);
    chk("random drop0", 64'(drop0), 64'(exp_drop[0]));
    chk("random drop1", 64'(drop1), 64'(exp_drop[1]));
    chk("random busy0", 64'(busy0), 64'd0);
    chk("random busy1", 64'(busy1), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
